lime_vector_checker: RTL

- Synthesizable, parametrised self-checking harness for the multi-cycle processor top (16-bit main_input / main_output).
- Replaces the single hard-coded stimulus with a programmable table of stimulus/expected pairs.
- Per vector: resets the DUT, applies the stimulus, waits for the result or a timeout, compares, and accumulates pass/fail statistics.
- Usable in simulation and on FPGA bring-up, with status driven to LEDs/debug.

---
 rtl/lime_pkg.sv | 25 ++
 rtl/lime_vector_table.sv | 33 +++
 rtl/lime_vector_checker.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lime_pkg.sv
// Shared types and width helpers for the vector checker and its stimulus table.
package lime_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    DUT_RST,
    RUN,
    CHECK,
    NEXT,
    DONE
  } state_t;

  // Width of an index into n entries (at least one bit so n==1 stays legal).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n >= 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/lime_vector_table.sv
// Stimulus/expected register file: synchronous write, combinational read.
module lime_vector_table
  import lime_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int NUM_VECTORS = 4,
  localparam int IW         = idx_w(NUM_VECTORS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_stim,
  input  logic [WIDTH-1:0] wr_exp,
  input  logic [IW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_stim,
  output logic [WIDTH-1:0] rd_exp
);

  logic [WIDTH-1:0] stim_mem [NUM_VECTORS];
  logic [WIDTH-1:0] exp_mem  [NUM_VECTORS];

  // Contents are deliberately not reset so a loaded table survives a run abort.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < NUM_VECTORS)) begin
      stim_mem[wr_addr] <= wr_stim;
      exp_mem[wr_addr]  <= wr_exp;
    end
  end

  assign rd_stim = stim_mem[rd_addr];
  assign rd_exp  = exp_mem[rd_addr];

endmodule

// File: rtl/lime_vector_checker.sv
// Runs every table vector against an external DUT: reset it, drive the stimulus,
// wait for a stable match or a timeout, and accumulate pass/fail statistics.
module lime_vector_checker
  import lime_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NUM_VECTORS    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int STABLE_CYCLES  = 8,
  parameter int RST_CYCLES     = 2,
  localparam int IW            = idx_w(NUM_VECTORS),
  localparam int CW            = cnt_w(NUM_VECTORS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tbl_wr_en,
  input  logic [IW-1:0]    tbl_wr_addr,
  input  logic [WIDTH-1:0] tbl_wr_stim,
  input  logic [WIDTH-1:0] tbl_wr_exp,
  input  logic             start,
  input  logic [WIDTH-1:0] dut_output,
  output logic [WIDTH-1:0] dut_input,
  output logic             dut_reset,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CW-1:0]    pass_count,
  output logic [CW-1:0]    fail_count,
  output logic [IW-1:0]    first_fail_idx,
  output logic [WIDTH-1:0] first_fail_val
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int RW = cnt_w(RST_CYCLES);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [RW-1:0]    rst_cnt;
  logic [TW-1:0]    cyc_cnt;
  logic [SW-1:0]    stab_cnt;
  logic [WIDTH-1:0] cur_exp;
  logic             verdict;

  logic [WIDTH-1:0] rd_stim;
  logic [WIDTH-1:0] rd_exp;
  logic             match;
  logic [TW-1:0]    cyc_next;
  logic [SW-1:0]    stab_next;

  lime_vector_table #(
    .WIDTH       (WIDTH),
    .NUM_VECTORS (NUM_VECTORS)
  ) u_table (
    .clk     (clk),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_stim (tbl_wr_stim),
    .wr_exp  (tbl_wr_exp),
    .rd_addr (idx),
    .rd_stim (rd_stim),
    .rd_exp  (rd_exp)
  );

  // Compare against the expected value latched for this run, not the live table.
  assign match     = (dut_output == cur_exp);
  assign cyc_next  = cyc_cnt + 1'b1;
  assign stab_next = match ? stab_cnt + 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      rst_cnt        <= '0;
      cyc_cnt        <= '0;
      stab_cnt       <= '0;
      cur_exp        <= '0;
      verdict        <= 1'b0;
      dut_input      <= '0;
      dut_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            idx            <= '0;
            rst_cnt        <= '0;
            done           <= 1'b0;
            all_pass       <= 1'b0;
            busy           <= 1'b1;
            dut_reset      <= 1'b1;
            state          <= DUT_RST;
          end
        end
        DUT_RST: begin
          dut_reset <= 1'b1;
          dut_input <= rd_stim;
          cur_exp   <= rd_exp;
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            dut_reset <= 1'b0;
            cyc_cnt   <= '0;
            stab_cnt  <= '0;
            state     <= RUN;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          cyc_cnt  <= cyc_next;
          stab_cnt <= stab_next;
          // A stable match takes priority over a timeout landing on the same cycle.
          if (stab_next == SW'(STABLE_CYCLES)) begin
            verdict <= 1'b1;
            state   <= CHECK;
          end else if (cyc_next == TW'(TIMEOUT_CYCLES)) begin
            verdict <= match;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (verdict) begin
            if (pass_count != CW'(NUM_VECTORS)) pass_count <= pass_count + 1'b1;
          end else begin
            if (fail_count == '0) begin
              first_fail_idx <= idx;
              first_fail_val <= dut_output;
            end
            if (fail_count != CW'(NUM_VECTORS)) fail_count <= fail_count + 1'b1;
          end
          state <= NEXT;
        end
        NEXT: begin
          dut_reset <= 1'b1;
          if (idx == IW'(NUM_VECTORS - 1)) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            all_pass <= (fail_count == '0);
            state    <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            rst_cnt <= '0;
            state   <= DUT_RST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
